// File: rtl/fw_pkg.sv
// Shared constants for the Floyd-Warshall tile datapath: tile geometry, stream word
// layout and the phase encodings carried alongside each tile.
package fw_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned W     = 16;
  localparam int unsigned LANES = 4;
  localparam int unsigned WPT   = N * N / LANES;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = LANES * W;

  localparam logic [1:0] PH_SELF  = 2'b00;
  localparam logic [1:0] PH_ROW   = 2'b01;
  localparam logic [1:0] PH_COL   = 2'b10;
  localparam logic [1:0] PH_OTHER = 2'b11;

  // True on the final word address of a tile.
  function automatic logic is_last_word(input logic [AW-1:0] cnt);
    return cnt == AW'(WPT - 1);
  endfunction

endpackage

// File: rtl/fw_tile_bank.sv
// One tile of storage: 16 x 64-bit words, synchronous write, registered read.
// The read register holds its value when no read is requested.
module fw_tile_bank
  import fw_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [WPT];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fw_collect.sv
// Collects the fw output stream into two ping-pong tile banks, applies backpressure when
// both are full and serves the oldest complete tile through a registered read port.
module fw_collect
  import fw_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] inD,
  input  logic          in_valid,
  input  logic [1:0]    phase,
  output logic          inhibit,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_done,
  output logic          tile_ready,
  output logic [1:0]    tile_phase,
  output logic [15:0]   tile_cnt,
  output logic          overflow
);

  logic [1:0]      bank_full_q, bank_full_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [1:0][1:0] phase_tag_q, phase_tag_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     tile_cnt_q, tile_cnt_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_sel_q, rd_sel_d;

  logic            accept, wr_last, rd_fire, rel_fire;
  logic [1:0]      bank_we, bank_re;
  logic [DW-1:0]   bank_rdata [2];

  always_comb begin
    inhibit    = bank_full_q[wr_bank_q];
    tile_ready = bank_full_q[rd_bank_q];
    tile_phase = phase_tag_q[rd_bank_q];

    accept   = in_valid & ~inhibit;
    wr_last  = accept & is_last_word(wr_cnt_q);
    rd_fire  = rd_req & tile_ready;
    rel_fire = rd_done & tile_ready;

    bank_we = 2'b00;
    bank_re = 2'b00;
    bank_we[wr_bank_q] = accept;
    bank_re[rd_bank_q] = rd_fire;
  end

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    phase_tag_d = phase_tag_q;
    overflow_d  = overflow_q;
    tile_cnt_d  = tile_cnt_q;
    rd_valid_d  = rd_fire;
    rd_sel_d    = rd_sel_q;

    if (rd_fire) begin
      rd_sel_d = rd_bank_q;
    end

    if (in_valid && inhibit) begin
      overflow_d = 1'b1;
    end

    if (accept) begin
      wr_cnt_d = wr_cnt_q + AW'(1);
      if (wr_cnt_q == '0) begin
        phase_tag_d[wr_bank_q] = phase;
      end
    end

    // Release and completion always touch different banks: the write bank is empty,
    // the read bank is full.
    if (rel_fire) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    if (wr_last) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
      wr_cnt_d               = '0;
      tile_cnt_d             = tile_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      phase_tag_q <= '0;
      overflow_q  <= 1'b0;
      tile_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      phase_tag_q <= phase_tag_d;
      overflow_q  <= overflow_d;
      tile_cnt_q  <= tile_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fw_tile_bank u_bank (
      .clk_i   (clk),
      .rst_i   (reset),
      .we_i    (bank_we[b]),
      .waddr_i (wr_cnt_q),
      .wdata_i (inD),
      .re_i    (bank_re[b]),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[b])
    );
  end

  // Each bank's read register holds, so steering by the last-read bank keeps rd_data stable.
  assign rd_data  = bank_rdata[rd_sel_q];
  assign rd_valid = rd_valid_q;
  assign tile_cnt = tile_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fw_collect.sv
// Bench for fw_collect: a queue-of-tiles reference model checked every cycle, a small
// vector table, hand-written lifecycle sequences and a randomized soak.
module tb_fw_collect;

  logic        clk = 1'b0;
  logic        reset, in_valid, rd_req, rd_done;
  logic [63:0] inD;
  logic [1:0]  phase;
  logic [3:0]  rd_addr;
  logic        inhibit, rd_valid, tile_ready, overflow;
  logic [63:0] rd_data;
  logic [1:0]  tile_phase;
  logic [15:0] tile_cnt;

  always #5 clk = ~clk;

  fw_collect dut (
    .clk        (clk),
    .reset      (reset),
    .inD        (inD),
    .in_valid   (in_valid),
    .phase      (phase),
    .inhibit    (inhibit),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_done    (rd_done),
    .tile_ready (tile_ready),
    .tile_phase (tile_phase),
    .tile_cnt   (tile_cnt),
    .overflow   (overflow)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: FIFO of completed tiles (16 words each) plus the partial tile.
  logic [63:0] m_words [$];
  logic [1:0]  m_ph    [$];
  logic [63:0] m_part  [$];
  logic [1:0]  m_part_ph;
  logic [15:0] m_cnt;
  logic        m_ovf, m_rv;
  logic [63:0] m_rd;

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        rq;
    logic [3:0]  a;
    logic        dn;
    logic        exp_rv;
    logic        exp_ready;
    logic        exp_inh;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic model_step(input logic rst, input logic iv, input logic [63:0] d,
                            input logic [1:0] ph, input logic rq, input logic [3:0] a,
                            input logic dn);
    int full;
    if (rst) begin
      m_words.delete(); m_ph.delete(); m_part.delete();
      m_cnt = '0; m_ovf = 1'b0; m_rv = 1'b0; m_rd = '0; m_part_ph = '0;
    end else begin
      full = m_ph.size();
      m_rv = rq && (full > 0);
      if (m_rv) m_rd = m_words[a];
      if (iv) begin
        if (full == 2) m_ovf = 1'b1;
        else begin
          if (m_part.size() == 0) m_part_ph = ph;
          m_part.push_back(d);
        end
      end
      if (dn && full > 0) begin
        for (int i = 0; i < 16; i++) void'(m_words.pop_front());
        void'(m_ph.pop_front());
      end
      if (m_part.size() == 16) begin
        foreach (m_part[i]) m_words.push_back(m_part[i]);
        m_ph.push_back(m_part_ph);
        m_part.delete();
        m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  task automatic compare_all();
    chk("inhibit", 64'(inhibit), 64'(m_ph.size() == 2));
    chk("tile_ready", 64'(tile_ready), 64'(m_ph.size() > 0));
    if (m_ph.size() > 0) chk("tile_phase", 64'(tile_phase), 64'(m_ph[0]));
    chk("tile_cnt", 64'(tile_cnt), 64'(m_cnt));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("rd_valid", 64'(rd_valid), 64'(m_rv));
    chk("rd_data", rd_data, m_rd);
  endtask

  task automatic cycle(input logic rst, input logic iv, input logic [63:0] d,
                       input logic [1:0] ph, input logic rq, input logic [3:0] a,
                       input logic dn);
    reset = rst; in_valid = iv; inD = d; phase = ph; rd_req = rq; rd_addr = a; rd_done = dn;
    model_step(rst, iv, d, ph, rq, a, dn);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 2'b00, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic word(input logic [63:0] d, input logic [1:0] ph);
    cycle(1'b0, 1'b1, d, ph, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 2'b00, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; inD = '0; phase = '0;
    rd_req = 1'b0; rd_addr = '0; rd_done = 1'b0;

    tbl[0] = '{1'b0, 64'h0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 64'h0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 64'h0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 64'hdead_beef_0000_0001, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4] = '{1'b0, 64'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    do_reset();
    do_reset();
    chk("rst_inhibit", 64'(inhibit), 64'd0);
    chk("rst_tile_ready", 64'(tile_ready), 64'd0);
    chk("rst_tile_phase", 64'(tile_phase), 64'd0);
    chk("rst_tile_cnt", 64'(tile_cnt), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);

    // Table: requests and releases with no tile ready have no effect.
    foreach (tbl[i]) begin
      cycle(1'b0, tbl[i].iv, tbl[i].d, 2'b00, tbl[i].rq, tbl[i].a, tbl[i].dn);
      chk($sformatf("tbl%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_ready", i), 64'(tile_ready), 64'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_inhibit", i), 64'(inhibit), 64'(tbl[i].exp_inh));
      chk($sformatf("tbl%0d_cnt", i), 64'(tile_cnt), 64'(tbl[i].exp_cnt));
    end
    do_reset();

    // First tile, phase 00.
    for (int i = 0; i < 16; i++) word(64'h004e_0057_0054_0000 + 64'(i), 2'b00);
    chk("t1_ready", 64'(tile_ready), 64'd1);
    chk("t1_cnt", 64'(tile_cnt), 64'd1);
    chk("t1_phase", 64'(tile_phase), 64'd0);
    cycle(1'b0, 1'b0, '0, 2'b00, 1'b1, 4'd0, 1'b0);
    chk("t1_rd_valid", 64'(rd_valid), 64'd1);
    chk("t1_rd_data", rd_data, 64'h004e_0057_0054_0000);

    // Second tile fills the other bank; 33rd word is dropped.
    for (int i = 0; i < 16; i++) word(64'h1000 + 64'(i), 2'b01);
    chk("t2_inhibit", 64'(inhibit), 64'd1);
    chk("t2_cnt", 64'(tile_cnt), 64'd2);
    word(64'hffff_ffff_ffff_ffff, 2'b01);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_cnt_after_drop", 64'(tile_cnt), 64'd2);

    // Release with both full, refill the freed bank.
    cycle(1'b0, 1'b0, '0, 2'b00, 1'b0, 4'd0, 1'b1);
    chk("t3_phase", 64'(tile_phase), 64'd1);
    chk("t3_inhibit", 64'(inhibit), 64'd0);
    for (int i = 0; i < 16; i++) word(64'h2000 + 64'(i), 2'b10);
    chk("t3_inhibit_full", 64'(inhibit), 64'd1);
    cycle(1'b0, 1'b0, '0, 2'b00, 1'b0, 4'd0, 1'b1);
    chk("t3_phase2", 64'(tile_phase), 64'd2);
    cycle(1'b0, 1'b0, '0, 2'b00, 1'b1, 4'd0, 1'b0);
    chk("t3_rd_data", rd_data, 64'h2000);

    // Completion coinciding with release of the other bank.
    for (int i = 0; i < 15; i++) word(64'h3000 + 64'(i), 2'b11);
    cycle(1'b0, 1'b1, 64'h300f, 2'b11, 1'b0, 4'd0, 1'b1);
    chk("t4_inhibit", 64'(inhibit), 64'd0);
    chk("t4_ready", 64'(tile_ready), 64'd1);
    chk("t4_cnt", 64'(tile_cnt), 64'd4);
    chk("t4_phase", 64'(tile_phase), 64'd3);

    // Reset mid-tile, then a fresh tile.
    for (int i = 0; i < 7; i++) word(64'h4000 + 64'(i), 2'b00);
    do_reset();
    chk("t5_ready", 64'(tile_ready), 64'd0);
    chk("t5_cnt", 64'(tile_cnt), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);
    chk("t5_rd_data", rd_data, 64'd0);
    for (int i = 0; i < 16; i++) word(64'h5000 + 64'(i), 2'b01);
    chk("t5_cnt1", 64'(tile_cnt), 64'd1);
    cycle(1'b0, 1'b0, '0, 2'b00, 1'b1, 4'd15, 1'b0);
    chk("t5_rd15", rd_data, 64'h500f);

    // Gaps of 1..3 idle cycles mid-tile.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      word(64'h6000 + 64'(i), 2'b10);
      for (int g = 0; g <= i % 3; g++) idle();
    end
    for (int a = 0; a < 16; a += 5) begin
      cycle(1'b0, 1'b0, '0, 2'b00, 1'b1, 4'(a), 1'b0);
      chk($sformatf("gap_rd%0d", a), rd_data, 64'h6000 + 64'(a));
    end

    // Randomized soak against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 7),
            {$urandom, $urandom}, 2'($urandom), ($urandom_range(0, 2) == 0),
            4'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
